// File: rtl/sonar_if.sv
// sonar_if: measure/ready/result handshake between the control unit and the sonar driver
interface sonar_if;
  logic       measure;
  logic       ready;
  logic [7:0] distance;
  logic       timeout;
  modport master (output measure, input ready, distance, timeout);
  modport slave (input measure, output ready, distance, timeout);
endinterface

// File: rtl/sonar_driver.sv
// sonar_driver: fires an HC-SR04 style ranger on request and reports the echo width in whole centimetres
module sonar_driver #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int RISE_TIMEOUT   = 50000,
  parameter int ECHO_TIMEOUT   = 1900000,
  parameter int HOLDOFF_CYCLES = 3000000
) (
  input  logic     clk,
  input  logic     rst,
  sonar_if.slave   bus,
  output logic     trig,
  input  logic     echo
);
  localparam int M1 = TRIG_CYCLES > RISE_TIMEOUT ? TRIG_CYCLES : RISE_TIMEOUT;
  localparam int M2 = ECHO_TIMEOUT > HOLDOFF_CYCLES ? ECHO_TIMEOUT : HOLDOFF_CYCLES;
  localparam int W = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam int PW = $clog2(CM_CYCLES + 1);
  localparam logic [W-1:0] TRIG_LAST = W'(TRIG_CYCLES - 1);
  localparam logic [W-1:0] RISE_LAST = W'(RISE_TIMEOUT - 1);
  localparam logic [W-1:0] ECHO_LAST = W'(ECHO_TIMEOUT - 1);
  localparam logic [W-1:0] HOLD_LAST = W'(HOLDOFF_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CM_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, ECHO_HIGH, DONE, HOLDOFF} state_t;
  state_t state, next;
  logic [W-1:0] cnt;
  logic [PW-1:0] pre;
  logic [7:0] cm, dist_q;
  logic tmo, tmo_n, tmo_q;
  logic echo_m, echo_s, echo_d;
  logic rise;
  assign rise = echo_s & ~echo_d;
  assign bus.ready = (state == IDLE) & ~bus.measure;
  assign bus.distance = dist_q;
  assign bus.timeout = tmo_q;
  always_comb begin
    next = state;
    tmo_n = tmo;
    case (state)
      IDLE: begin
        next = bus.measure ? TRIG : IDLE;
        tmo_n = bus.measure ? 1'b0 : tmo;
      end
      TRIG: next = (cnt == TRIG_LAST) ? WAIT_RISE : TRIG;
      WAIT_RISE: begin
        next = rise ? ECHO_HIGH : (cnt == RISE_LAST) ? DONE : WAIT_RISE;
        tmo_n = ~rise & (cnt == RISE_LAST);
      end
      ECHO_HIGH: begin
        next = (!echo_s || cnt == ECHO_LAST) ? DONE : ECHO_HIGH;
        tmo_n = echo_s & (cnt == ECHO_LAST);
      end
      DONE: next = HOLDOFF;
      HOLDOFF: next = (cnt == HOLD_LAST) ? IDLE : HOLDOFF;
      default: next = IDLE;
    endcase
  end
  // cnt restarts at 0 on every state change and idles at 0, so it never wraps inside a state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
      cm <= '0;
      tmo <= 1'b0;
      trig <= 1'b0;
      dist_q <= '0;
      tmo_q <= 1'b0;
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
      state <= next;
      tmo <= tmo_n;
      cnt <= (next != state || state == IDLE) ? '0 : cnt + W'(1);
      trig <= (state == TRIG);
      if (state == WAIT_RISE) begin
        pre <= '0;
        cm <= '0;
      end else if (state == ECHO_HIGH && echo_s) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        if (pre == PRE_LAST && cm != 8'hFF) cm <= cm + 8'd1;
      end
      if (state == DONE) begin
        dist_q <= tmo ? 8'hFF : cm;
        tmo_q <= tmo;
      end
    end
  end
endmodule

// File: doc/sonar_driver.md
# sonar_driver

Responder side of the control unit's sonar handshake: accepts a one-cycle `measure` pulse and fires an ultrasonic ranger (HC-SR04 style trigger/echo). It times the returned echo pulse and presents an 8-bit distance in centimetres with `ready`. It sits between the control unit and the sensor pins, and owns trigger generation, echo synchronisation, timeouts and the sensor recovery hold-off.

## Interface
Parameters (defaults assume a 50 MHz clock):
- `TRIG_CYCLES`, 500: trigger high time (10 µs).
- `CM_CYCLES`, 2900: echo-high clocks per centimetre (58 µs).
- `RISE_TIMEOUT`, 50000: maximum clocks waiting for the echo rising edge.
- `ECHO_TIMEOUT`, 1900000: maximum clocks of echo high (38 ms).
- `HOLDOFF_CYCLES`, 3000000: sensor recovery time before `ready` returns (60 ms).

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: **reset is asynchronous and active-high**.
- `measure` input 1: start request, a one-cycle pulse from the control unit.
- `ready` output 1: idle, and `distance`/`timeout` are valid.
- `distance` output 8: last result in cm, saturating at 255.
- `timeout` output 1: last measurement aborted; `distance` = 8'hFF.
- `trig` output 1: to the sensor trigger pin.
- `echo` input 1: from the sensor echo pin; asynchronous.

## Operation
- `echo` passes through a 2-FF synchroniser (`echo_s`), plus one delay register (`echo_d`) for edge detection.
- `ready` = (state == IDLE) & !`measure`, combinational.
  - This makes `ready` drop in the same cycle `measure` is high, so the requester never samples a stale `ready`.
- States:
  - IDLE: on `measure`=1, go to TRIG and clear the cycle counter.
  - TRIG: `trig`=1 for exactly `TRIG_CYCLES` clocks, then go to WAIT_RISE.
  - WAIT_RISE: on a rising edge (`echo_s`=1, `echo_d`=0), go to ECHO_HIGH and clear the cm prescaler and the cm count. If the counter reaches `RISE_TIMEOUT` first, go to DONE with the timeout flag set.
  - ECHO_HIGH: the prescaler counts 0..`CM_CYCLES`-1 and wraps. Each wrap increments the cm count, saturating at 255. On `echo_s`=0, go to DONE with the cm count. If the counter reaches `ECHO_TIMEOUT`, go to DONE with the timeout flag set.
  - DONE (one cycle): latch `distance` (cm count, or 8'hFF on timeout) and `timeout`, then go to HOLDOFF.
  - HOLDOFF: wait `HOLDOFF_CYCLES` clocks, then go to IDLE.
- Only complete centimetres are counted; a partial final period is discarded.
- `measure` outside IDLE is ignored and is not queued.
- A rising edge is required to start timing. An echo already high when WAIT_RISE is entered does not count, and ends in a rise timeout.
- Counter widths are sized to the largest parameter (≥22 bits at the defaults). No counter may wrap within a state.

## Timing
- Reset values: `trig`=0, `distance`=0, `timeout`=0, state IDLE. `ready` then follows `measure` combinationally.
- Asserting `rst` mid-operation forces `trig` low immediately and discards any partial result.
- Trigger timing:
  - `measure` sampled high at edge N: `trig`=1 from edge N+1 through edge N+`TRIG_CYCLES`, then 0.
- Echo timing:
  - Echo edges are seen 2 cycles late through the synchroniser. Both edges are delayed equally, so the measured width is unaffected.
  - A falling edge on `echo_s` at edge M: DONE at M+1, `distance`/`timeout` updated at M+2.
- `ready` returns high `HOLDOFF_CYCLES` clocks after DONE.
- `distance` and `timeout` stay stable from DONE until the next DONE, including while busy.

## Test plan
All scenarios use parameters TRIG=4, CM=10, RISE=50, ECHO=3000, HOLDOFF=20.
- Normal measurement: `measure` pulse; echo rises 5 cycles after `trig` falls and stays high 125 cycles -> `trig` high exactly 4 cycles, `distance`=12, `timeout`=0. `ready` is low in the `measure` cycle and returns 20 cycles after DONE.
- No echo: `measure` pulse with `echo` held 0 -> after 50 cycles in WAIT_RISE, `distance`=8'hFF, `timeout`=1.
- Saturation and echo timeout:
  - Echo high for 2600 cycles -> `distance`=255, `timeout`=0.
  - Echo held high -> timeout after 3000 cycles, `distance`=8'hFF, `timeout`=1.
- Busy requests: `measure` re-pulsed during TRIG, ECHO_HIGH and HOLDOFF -> ignored. Exactly one `trig` pulse; the result matches a single measurement.
- Reset mid-measurement: `rst` asserted during TRIG, then during ECHO_HIGH (echo high 60 cycles) -> `trig`=0 asynchronously, `distance`=0, `timeout`=0. After release, the next `measure` yields a correct result.
- Echo already high: echo high before `measure` and held throughout -> no rising edge seen, rise timeout, `timeout`=1.
